// File: rtl/sm_bus_arbiter.sv
// Two-requester arbiter that shares one bus-matrix request port.
// A grant is held until the matrix completes or the watchdog aborts the transaction.
module sm_bus_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 256,
    parameter int CNT_W     = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a0,
    input  logic        we0,
    input  logic [31:0] wd0,
    input  logic        valid0,
    output logic        ready0,
    output logic [31:0] rd0,
    input  logic [31:0] a1,
    input  logic        we1,
    input  logic [31:0] wd1,
    input  logic        valid1,
    output logic        ready1,
    output logic [31:0] rd1,
    output logic [31:0] m_a,
    output logic        m_we,
    output logic [31:0] m_wd,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic [31:0] m_rd,
    output logic [1:0]  grant,
    output logic        err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit               WD_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LIM = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [31:0]      ABORT_RD = 32'hDEAD_BEEF;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic busy;
    logic done;
    logic abort;
    logic winner;
    logic [31:0] resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign busy  = (state == BUSY);
    assign done  = busy & m_ready;
    // m_ready wins over a coincident watchdog expiry
    assign abort = busy & ~m_ready & WD_EN & (cnt == CNT_LIM);

    always_comb begin
        winner = valid1;
        if (valid0 && valid1) begin
            winner = (PRIO_MODE != 0) ? 1'b0 : ~last;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (valid0 || valid1) begin
                    state_nxt = BUSY;
                    owner_nxt = winner;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (done || abort) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m_valid = busy;
    assign m_a     = busy ? (owner ? a1  : a0)  : '0;
    assign m_we    = busy & (owner ? we1 : we0);
    assign m_wd    = busy ? (owner ? wd1 : wd0) : '0;
    assign grant   = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

    assign resp   = done ? m_rd : ABORT_RD;
    assign ready0 = (done | abort) & ~owner;
    assign ready1 = (done | abort) & owner;
    assign rd0    = ready0 ? resp : '0;
    assign rd1    = ready1 ? resp : '0;
    assign err    = abort;

endmodule

// File: tb/tb_sm_bus_arbiter.sv
// Random-stimulus bench: a round-robin and a fixed-priority arbiter run side by side,
// each checked every cycle against a transaction-level reference model.
module tb_sm_bus_arbiter;

    localparam int TO = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a0[2], wd0[2], a1[2], wd1[2], m_rd[2];
    logic        we0[2], we1[2], valid0[2], valid1[2], m_ready[2];
    logic        ready0[2], ready1[2], m_we[2], m_valid[2], err[2];
    logic [31:0] rd0[2], rd1[2], m_a[2], m_wd[2];
    logic [1:0]  grant[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sm_bus_arbiter #(.PRIO_MODE(g), .TIMEOUT(TO), .CNT_W(4)) u_dut (
            .clk(clk), .rst(rst),
            .a0(a0[g]), .we0(we0[g]), .wd0(wd0[g]), .valid0(valid0[g]),
            .ready0(ready0[g]), .rd0(rd0[g]),
            .a1(a1[g]), .we1(we1[g]), .wd1(wd1[g]), .valid1(valid1[g]),
            .ready1(ready1[g]), .rd1(rd1[g]),
            .m_a(m_a[g]), .m_we(m_we[g]), .m_wd(m_wd[g]), .m_valid(m_valid[g]),
            .m_ready(m_ready[g]), .m_rd(m_rd[g]),
            .grant(grant[g]), .err(err[g])
        );
    end

    int n_vec = 0;
    int n_bad = 0;

    // reference model: in-transaction flag, owner, last served, BUSY cycles already spent
    bit mb[2];
    int mo[2], ml[2], mg[2];
    bit got0[2], got1[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input int pv, input int pr, input bit do_rst);
        bit          e_done, e_ab, e_r0, e_r1;
        logic [31:0] e_a, e_wd, e_resp;
        logic        e_we;
        logic [1:0]  e_gnt;
        @(negedge clk);
        rst = do_rst;
        for (int i = 0; i < 2; i++) begin
            if (!valid0[i] || got0[i]) begin
                valid0[i] = ($urandom_range(99) < pv);
                a0[i] = $urandom; wd0[i] = $urandom; we0[i] = 1'($urandom_range(1));
            end
            if (!valid1[i] || got1[i]) begin
                valid1[i] = ($urandom_range(99) < pv);
                a1[i] = $urandom; wd1[i] = $urandom; we1[i] = 1'($urandom_range(1));
            end
            m_ready[i] = ($urandom_range(99) < pr);
            m_rd[i]    = $urandom;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            if (do_rst) begin
                mb[i] = 0; mo[i] = 0; ml[i] = 1; mg[i] = 0;
            end
            e_done = mb[i] && m_ready[i];
            e_ab   = mb[i] && !m_ready[i] && (TO > 0) && (mg[i] + 1 == TO);
            e_r0   = (e_done || e_ab) && mo[i] == 0;
            e_r1   = (e_done || e_ab) && mo[i] == 1;
            e_resp = e_done ? m_rd[i] : 32'hDEAD_BEEF;
            e_a    = !mb[i] ? 32'd0 : (mo[i] == 1 ? a1[i] : a0[i]);
            e_wd   = !mb[i] ? 32'd0 : (mo[i] == 1 ? wd1[i] : wd0[i]);
            e_we   = mb[i] && (mo[i] == 1 ? we1[i] : we0[i]);
            e_gnt  = !mb[i] ? 2'b00 : (mo[i] == 1 ? 2'b10 : 2'b01);
            chk($sformatf("u%0d ctl{mv,we,gnt,r0,r1,err}", i),
                {57'd0, m_valid[i], m_we[i], grant[i], ready0[i], ready1[i], err[i]},
                {57'd0, mb[i], e_we, e_gnt, e_r0, e_r1, e_ab});
            chk($sformatf("u%0d m_a/m_wd", i), {m_a[i], m_wd[i]}, {e_a, e_wd});
            chk($sformatf("u%0d rd0/rd1", i), {rd0[i], rd1[i]},
                {e_r0 ? e_resp : 32'd0, e_r1 ? e_resp : 32'd0});
            got0[i] = e_r0;
            got1[i] = e_r1;
            if (!do_rst) begin
                if (!mb[i]) begin
                    if (valid0[i] || valid1[i]) begin
                        if (valid0[i] && valid1[i]) mo[i] = (i == 1) ? 0 : 1 - ml[i];
                        else                        mo[i] = valid1[i] ? 1 : 0;
                        mb[i] = 1;
                        mg[i] = 0;
                    end
                end else if (e_done || e_ab) begin
                    mb[i] = 0;
                    ml[i] = mo[i];
                end else begin
                    mg[i]++;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            a0[i] = '0; wd0[i] = '0; we0[i] = 1'b0; valid0[i] = 1'b0;
            a1[i] = '0; wd1[i] = '0; we1[i] = 1'b0; valid1[i] = 1'b0;
            m_ready[i] = 1'b0; m_rd[i] = '0;
            mb[i] = 0; mo[i] = 0; ml[i] = 1; mg[i] = 0;
            got0[i] = 0; got1[i] = 0;
        end
        for (int k = 0; k < 3; k++) cycle(100, 100, 1'b1);
        // continuous contention with a zero-wait matrix
        for (int k = 0; k < 40; k++) cycle(100, 100, 1'b0);
        // mixed traffic and matrix latency
        for (int k = 0; k < 300; k++) cycle(60, 50, 1'b0);
        // stalled matrix drives the watchdog
        for (int k = 0; k < 60; k++) cycle(100, 5, 1'b0);
        // asynchronous resets landing mid-transaction
        for (int k = 0; k < 300; k++) cycle(70, 30, $urandom_range(39) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
